muldiv_unit: RTL and testbench

- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core. Sits in the EX stage beside the ALU.
- Operations arrive pre-decoded as a 4-bit op code.
- Adds three things over the previous generation:
  - generic WIDTH;
  - configurable multiply latency;
  - a true bit-serial restoring divider, plus MADD/MADDU/MSUB/MSUBU accumulate modes.
- The stall unit stalls any MF/MT/muldiv instruction in EX while busy=1.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_unit_div_core.sv | 70 +++++++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op/state encodings and sizing helper for the HI/LO multiply/divide unit
//
// Contents:
//   op_e      : pre-decoded 4-bit operation codes from the EX stage decoder
//   state_e   : control FSM states
//   cnt_width : width of the shared latency/iteration counter
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_PREP,
        ST_ITER,
        ST_FIX
    } state_e;

    // One counter serves both the multiply latency and the divide iterations,
    // so it must hold the larger of the two.
    function automatic int cnt_width(input int mul_lat, input int width);
        int m;
        m = (mul_lat > width) ? mul_lat : width;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-stage request/result bundle of the multiply/divide unit
//
// Signals:
//   op, start, a, b, req : operation request from EX (req = flush, blocks acceptance)
//   busy, done, hi, lo   : unit status and the architectural HI/LO registers
// Modports: master (EX stage / stall logic), slave (muldiv_unit)
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       op;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op, start, a, b, req,
        input  busy, done, hi, lo
    );

    modport slave (
        input  op, start, a, b, req,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - unsigned restoring divider datapath, one quotient bit per step
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   load_i        : capture dividend/divisor magnitudes and clear the remainder
//   step_i        : perform one restoring iteration
//   dividend_i    : unsigned dividend
//   divisor_i     : unsigned divisor
//   quotient_o    : quotient shift register (valid after WIDTH steps)
//   remainder_o   : partial remainder (valid after WIDTH steps)
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        // The dividend bits are consumed MSB-first out of the quotient register
        // while quotient bits fill in from the bottom.
        shifted = {rem_q, quo_q[WIDTH-1]};
        // When shifted >= divisor the true difference is below the divisor, so
        // it always fits in WIDTH bits.
        trial   = shifted[WIDTH-1:0] - dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = trial;
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/accumulate/divide unit for the EX stage
//
// Parameters: WIDTH (operand/HI/LO width), MUL_LAT (1..15, accept-to-commit edges for multiplies)
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : muldiv_if.slave (op/start/a/b/req in, busy/done/hi/lo out)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);

    localparam int            CW        = cnt_width(MUL_LAT, WIDTH);
    localparam logic [CW-1:0] MUL_LOAD  = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] ITER_LOAD = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Holds the finished product for multiplies, or the raw {a,b} operands
    // between accept and PREP for divides.
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               sgn_q, sgn_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               bzero_q, bzero_d;

    logic               accept;
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, mul_res;
    logic [WIDTH-1:0]   div_a, div_b, mag_a, mag_b;
    logic [WIDTH-1:0]   quo, rem;
    logic               div_load, div_step;

    assign accept = bus.start && !bus.req && (state_q == ST_IDLE);

    // Multiply datapath: extending both operands to 2*WIDTH and keeping the
    // low half of the product gives the correct signed or unsigned result.
    always_comb begin
        mul_signed = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
        ext_a = mul_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
        ext_b = mul_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
        prod  = ext_a * ext_b;
        acc   = {hi_q, lo_q};
        case (bus.op)
            OP_MADD, OP_MADDU: mul_res = acc + prod;
            OP_MSUB, OP_MSUBU: mul_res = acc - prod;
            default:           mul_res = prod;
        endcase
    end

    assign div_a = res_q[2*WIDTH-1:WIDTH];
    assign div_b = res_q[WIDTH-1:0];
    assign mag_a = (sgn_q && div_a[WIDTH-1]) ? -div_a : div_a;
    assign mag_b = (sgn_q && div_b[WIDTH-1]) ? -div_b : div_b;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk         (clk),
        .reset       (reset),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        sgn_d    = sgn_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        bzero_d  = bzero_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            res_d   = mul_res;
                            cnt_d   = MUL_LOAD;
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_d   = {bus.a, bus.b};
                            sgn_d   = (bus.op == OP_DIV);
                            state_d = ST_PREP;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = res_q;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PREP: begin
                div_load = 1'b1;
                // Quotient sign follows the operand signs; remainder follows a.
                q_neg_d  = sgn_q && (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
                r_neg_d  = sgn_q && div_a[WIDTH-1];
                bzero_d  = (div_b == '0);
                cnt_d    = ITER_LOAD;
                state_d  = ST_ITER;
            end
            ST_ITER: begin
                div_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIX: begin
                // Divide by zero runs the full latency but leaves HI/LO alone.
                // MIN / -1 falls out naturally: magnitude quotient 2^(W-1), positive sign.
                if (!bzero_q) begin
                    lo_d = q_neg_q ? -quo : quo;
                    hi_d = r_neg_q ? -rem : rem;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            bzero_q <= bzero_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W    = 32;
    localparam int LAT  = 5;
    localparam int DLAT = W + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vecs = 0;
    int errs = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sp;
        longint unsigned up;
        longint unsigned acc;
        int              sa;
        int              sb;
        sa  = $signed(a);
        sb  = $signed(b);
        sp  = longint'(sa) * longint'(sb);
        up  = longint'({32'b0, a}) * longint'({32'b0, b});
        acc = {m_hi, m_lo};
        case (op)
            4'd1: {m_hi, m_lo} = sp;
            4'd2: {m_hi, m_lo} = up;
            4'd5: {m_hi, m_lo} = acc + sp;
            4'd6: {m_hi, m_lo} = acc + up;
            4'd7: {m_hi, m_lo} = acc - sp;
            4'd8: {m_hi, m_lo} = acc - up;
            4'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && sb == -1) begin
                    m_lo = a;
                    m_hi = '0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd9:  m_hi = a;
            4'd10: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd3 || op == 4'd4) return DLAT;
        if (op == 4'd1 || op == 4'd2 || (op >= 4'd5 && op <= 4'd8)) return LAT;
        return 0;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        int lat;
        int n;
        lat = lat_of(op);
        model(op, a, b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        bus.req   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (lat == 0) begin
            vecs++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errs++;
                $display("FAIL %s busy/done: got %b/%b want 0/0", name, bus.busy, bus.done);
            end
        end else begin
            n = 0;
            while (bus.busy === 1'b1 && n < 100) begin
                n++;
                @(posedge clk); #1;
            end
            vecs++;
            if (n != lat) begin
                errs++;
                $display("FAIL %s latency: got %0d want %0d", name, n, lat);
            end
            if (!((op == 4'd3 || op == 4'd4) && b == 0)) begin
                vecs++;
                if (bus.done !== 1'b1) begin
                    errs++;
                    $display("FAIL %s done pulse: got %b want 1", name, bus.done);
                end
            end
            @(posedge clk); #1;
            vecs++;
            if (bus.done !== 1'b0) begin
                errs++;
                $display("FAIL %s done width: got %b want 0", name, bus.done);
            end
        end
        vecs++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            errs++;
            $display("FAIL %s hi/lo: got %h/%h want %h/%h", name, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.req   = 1'b0;
        bus.op    = 4'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            errs++;
            $display("FAIL reset state: got busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_directed();
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
        run_op(OP_MTHI, 32'd0, 32'd0, "mthi");
        run_op(OP_MTLO, 32'd10, 32'd0, "mtlo");
        run_op(OP_MADDU, 32'hFFFF_FFFF, 32'd2, "maddu");
        run_op(OP_MSUB, 32'd1, 32'd20, "msub");
        run_op(OP_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "madd_m1xm1");
        run_op(OP_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu_max");
    endtask

    task automatic test_div_directed();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, "divu_m7_2");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(OP_DIVU, 32'd5, 32'd0, "divu_by_zero");
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    endtask

    task automatic test_req_ignored();
        bus.op    = OP_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        bus.start = 1'b1;
        bus.req   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.req   = 1'b0;
        vecs++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL req_flush busy: got %b want 0", bus.busy);
        end
        repeat (LAT + 1) @(posedge clk);
        #1;
        vecs++;
        if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b0) begin
            errs++;
            $display("FAIL req_flush hi/lo/done: got %h/%h/%b want %h/%h/0",
                     bus.hi, bus.lo, bus.done, m_hi, m_lo);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i >= 11) run_op(4'(i), $urandom, $urandom, "undefined_op");
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        model(OP_DIV, 32'd1000, 32'hFFFF_FFF9);
        bus.op    = OP_DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'hFFFF_FFF9;
        bus.start = 1'b1;
        bus.req   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (n == 3) begin
                bus.op    = OP_MULT;
                bus.a     = 32'd123;
                bus.b     = 32'd456;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        vecs++;
        if (n != DLAT) begin
            errs++;
            $display("FAIL busy_start latency: got %0d want %0d", n, DLAT);
        end
        @(posedge clk); #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            errs++;
            $display("FAIL busy_start result: got busy=%b %h/%h want busy=0 %h/%h",
                     bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_async_reset();
        run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi_pre_reset");
        run_op(OP_MTLO, 32'h1234_5678, 32'd0, "mtlo_pre_reset");
        bus.op    = OP_DIV;
        bus.a     = 32'd99;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            errs++;
            $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(OP_MULTU, 32'd6, 32'd7, "multu_after_reset");
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 10));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_req_ignored();
        test_start_while_busy();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
